// File: rtl/tb_mem_arbiter_if.sv
// ============================================================================
//  Module      : tb_mem_arbiter_if
//  Description : Requester and SRAM-side bus of the testbench memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tb_mem_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_WORDS  = 256,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
);
  localparam int c_word_aw = $clog2(NUM_WORDS);

  logic [NUM_REQ-1:0]                     req_i;
  logic [NUM_REQ-1:0]                     we_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_i;
  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   be_i;
  logic [NUM_REQ-1:0]                     gnt_o;
  logic [NUM_REQ-1:0]                     rvalid_o;
  logic [DATA_WIDTH-1:0]                  rdata_o;
  logic                                   init_done_o;
  logic                                   mem_req_o;
  logic                                   mem_we_o;
  logic [c_word_aw-1:0]                   mem_addr_o;
  logic [DATA_WIDTH-1:0]                  mem_wdata_o;
  logic [DATA_WIDTH/8-1:0]                mem_be_o;
  logic [DATA_WIDTH-1:0]                  mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, init_done_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, init_done_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

`default_nettype wire

// File: rtl/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Zero-fills a shared single-port SRAM, then round-robin
//                arbitrates it between requesters with 1-cycle responses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_WORDS  = 256,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  tb_mem_arbiter_if.slave    bus
);
  localparam int c_word_aw  = $clog2(NUM_WORDS);
  localparam int c_byte_off = $clog2(DATA_WIDTH / 8);
  localparam int c_ptr_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_word_aw-1:0] c_last_word = c_word_aw'(NUM_WORDS - 1);
  localparam logic [c_ptr_w:0]     c_nreq      = (c_ptr_w + 1)'(NUM_REQ);
  localparam logic [c_ptr_w-1:0]   c_last_req  = c_ptr_w'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [c_ptr_w-1:0]    w_ptr_nxt;
  logic [c_word_aw-1:0]  r_fill_cnt;
  logic                  r_init_done;
  logic [NUM_REQ-1:0]    r_rvalid;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_found;
  logic [c_ptr_w-1:0]    w_winner;
  logic [c_ptr_w:0]      v_idx;

  // Scan from the pointer upward, wrapping; first active request wins.
  always_comb begin
    w_gnt    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    if (rst_ni && (r_state == ST_RUN)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        v_idx = {1'b0, r_ptr} + k[c_ptr_w:0];
        if (v_idx >= c_nreq) v_idx = v_idx - c_nreq;
        if (!w_found && bus.req_i[v_idx[c_ptr_w-1:0]]) begin
          w_found  = 1'b1;
          w_winner = v_idx[c_ptr_w-1:0];
        end
      end
    end
    if (w_found) w_gnt[w_winner] = 1'b1;
  end

  assign w_ptr_nxt = (w_winner == c_last_req) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_INIT) && (r_fill_cnt == c_last_word)) w_state_nxt = ST_RUN;
  end

  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = r_fill_cnt;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '1;
    if (rst_ni) begin
      case (r_state)
        ST_INIT: begin
          bus.mem_req_o = 1'b1;
          bus.mem_we_o  = 1'b1;
        end
        default: begin
          bus.mem_req_o   = w_found;
          bus.mem_we_o    = w_found & bus.we_i[w_winner];
          bus.mem_addr_o  = bus.addr_i[w_winner][c_byte_off +: c_word_aw];
          bus.mem_wdata_o = bus.wdata_i[w_winner];
          bus.mem_be_o    = bus.be_i[w_winner];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= INIT_ZERO ? ST_INIT : ST_RUN;
      r_ptr       <= '0;
      r_fill_cnt  <= '0;
      r_init_done <= 1'b0;
      r_rvalid    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_gnt;
      if (w_found) r_ptr <= w_ptr_nxt;
      if (r_state == ST_INIT) r_fill_cnt <= r_fill_cnt + 1'b1;
      if (w_state_nxt == ST_RUN) r_init_done <= 1'b1;
    end
  end

  assign bus.gnt_o       = w_gnt;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign bus.init_done_o = r_init_done;

  // Upper address bits alias by design.
  logic w_unused;
  assign w_unused = ^bus.addr_i;
endmodule

`default_nettype wire

// File: tb/tb_tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_tb_mem_arbiter
//  Description : Directed self-checking bench for tb_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tb_mem_arbiter_if #(.NUM_REQ(2), .NUM_WORDS(256), .DATA_WIDTH(64), .ADDR_WIDTH(12)) bus ();

  tb_mem_arbiter #(
    .NUM_REQ(2), .NUM_WORDS(256), .DATA_WIDTH(64), .ADDR_WIDTH(12), .INIT_ZERO(1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // SRAM model, seeded with non-zero garbage so the zero-fill is observable.
  logic [63:0] sram [256];
  logic [63:0] sram_q = '0;
  logic        sram_seeded = 1'b0;
  assign bus.mem_rdata_i = sram_q;

  always @(posedge clk) begin
    if (!sram_seeded) begin
      for (int i = 0; i < 256; i++) sram[i] <= 64'hA5A5_A5A5_0000_0000 | 64'(i);
      sram_seeded <= 1'b1;
    end else if (bus.mem_req_o) begin
      sram_q <= sram[bus.mem_addr_o];
      if (bus.mem_we_o)
        for (int b = 0; b < 8; b++)
          if (bus.mem_be_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_check(input int n);
    for (int a = 0; a < n; a++) begin
      if (a > 0) @(negedge clk);
      #1;
      check("fill_ctl", 64'({bus.mem_req_o, bus.mem_we_o, bus.gnt_o, bus.init_done_o, bus.mem_be_o}),
            64'({1'b1, 1'b1, 2'b00, 1'b0, 8'hFF}));
      check("fill_addr", 64'(bus.mem_addr_o), 64'(a));
      check("fill_wdata", bus.mem_wdata_o, 64'h0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.be_i    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 64'(bus.gnt_o), 64'h0);
    check("rst_rvalid", 64'(bus.rvalid_o), 64'h0);
    check("rst_mem_req", 64'(bus.mem_req_o), 64'h0);
    check("rst_mem_we", 64'(bus.mem_we_o), 64'h0);
    check("rst_init_done", 64'(bus.init_done_o), 64'h0);

    // Read of the last word stays pending through the whole fill.
    @(negedge clk);
    bus.req_i     = 2'b01;
    bus.addr_i[0] = 12'h7F8;
    bus.be_i[0]   = 8'hFF;
    rst_n         = 1'b1;
    fill_check(256);
    @(negedge clk); #1;
    check("run_init_done", 64'(bus.init_done_o), 64'h1);
    check("first_run_gnt", 64'(bus.gnt_o), 64'h1);
    check("first_run_addr", 64'(bus.mem_addr_o), 64'd255);
    check("first_run_we", 64'(bus.mem_we_o), 64'h0);
    @(negedge clk); bus.req_i = 2'b00; #1;
    check("zero_rvalid", 64'(bus.rvalid_o), 64'h1);
    check("zero_rdata", bus.rdata_o, 64'h0);
    check("idle_gnt", 64'(bus.gnt_o), 64'h0);

    // Write then read back through requester 0.
    @(negedge clk);
    bus.req_i = 2'b01; bus.we_i[0] = 1'b1; bus.addr_i[0] = 12'h010;
    bus.wdata_i[0] = 64'hDEADBEEF_CAFEF00D; bus.be_i[0] = 8'hFF;
    #1;
    check("wr_gnt", 64'(bus.gnt_o), 64'h1);
    check("wr_addr", 64'(bus.mem_addr_o), 64'd2);
    check("wr_we", 64'(bus.mem_we_o), 64'h1);
    check("wr_wdata", bus.mem_wdata_o, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk); bus.we_i[0] = 1'b0; #1;
    check("wr_rvalid", 64'(bus.rvalid_o), 64'h1);
    check("rd_gnt", 64'(bus.gnt_o), 64'h1);
    check("rd_addr", 64'(bus.mem_addr_o), 64'd2);
    check("rd_we", 64'(bus.mem_we_o), 64'h0);
    @(negedge clk); bus.req_i = 2'b00; #1;
    check("rd_rvalid", 64'(bus.rvalid_o), 64'h1);
    check("rd_rdata", bus.rdata_o, 64'hDEADBEEF_CAFEF00D);

    // Requester 1 alone moves the pointer back to 0, then alternate.
    @(negedge clk); bus.req_i = 2'b10; bus.we_i = 2'b00; bus.addr_i[1] = 12'h000; #1;
    check("solo1_gnt", 64'(bus.gnt_o), 64'h2);
    @(negedge clk); bus.req_i = 2'b11;
    begin
      logic [1:0] prev_gnt;
      logic [1:0] exp_gnt;
      prev_gnt = 2'b10;
      for (int i = 0; i < 6; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_gnt", 64'(bus.gnt_o), 64'(exp_gnt));
        check("rr_rvalid", 64'(bus.rvalid_o), 64'(prev_gnt));
        prev_gnt = exp_gnt;
      end
    end
    @(negedge clk); bus.req_i = 2'b10; #1;
    check("rr_last_rvalid", 64'(bus.rvalid_o), 64'h2);
    check("solo1b_gnt", 64'(bus.gnt_o), 64'h2);
    @(negedge clk); bus.req_i = 2'b11; #1;
    check("both_after_solo1", 64'(bus.gnt_o), 64'h1);

    // Pointer now 1; a withdrawn request must not move it.
    @(negedge clk); bus.req_i = 2'b11; #1;
    check("ptr1_gnt", 64'(bus.gnt_o), 64'h2);
    @(negedge clk); bus.req_i = 2'b00; #1;
    check("drop_gnt", 64'(bus.gnt_o), 64'h0);
    @(negedge clk); bus.req_i = 2'b11; #1;
    check("ptr_held_gnt", 64'(bus.gnt_o), 64'h1);

    // Aliasing through requester 1, then a partial-byte write.
    @(negedge clk);
    bus.req_i = 2'b10; bus.we_i = 2'b10; bus.addr_i[1] = 12'h008;
    bus.wdata_i[1] = 64'h1; bus.be_i[1] = 8'hFF;
    #1;
    check("alias_wr_gnt", 64'(bus.gnt_o), 64'h2);
    check("alias_wr_addr", 64'(bus.mem_addr_o), 64'd1);
    @(negedge clk); bus.we_i = 2'b00; bus.addr_i[1] = 12'h808; #1;
    check("alias_rd_addr", 64'(bus.mem_addr_o), 64'd1);
    @(negedge clk);
    bus.we_i = 2'b10; bus.wdata_i[1] = 64'hFFFF_FFFF_FFFF_FFFF; bus.be_i[1] = 8'h02;
    #1;
    check("alias_rd_rvalid", 64'(bus.rvalid_o), 64'h2);
    check("alias_rd_rdata", bus.rdata_o, 64'h1);
    @(negedge clk); bus.we_i = 2'b00; bus.addr_i[1] = 12'h008; bus.be_i[1] = 8'hFF;
    @(negedge clk); bus.req_i = 2'b00; #1;
    check("be_rvalid", 64'(bus.rvalid_o), 64'h2);
    check("be_rdata", bus.rdata_o, 64'h0000_0000_0000_FF01);

    // Reset during a read grant drops the response.
    @(negedge clk); bus.req_i = 2'b01; bus.addr_i[0] = 12'h010; #1;
    check("pre_rst_gnt", 64'(bus.gnt_o), 64'h1);
    rst_n = 1'b0; #1;
    check("in_rst_gnt", 64'(bus.gnt_o), 64'h0);
    check("in_rst_mem_req", 64'(bus.mem_req_o), 64'h0);
    @(negedge clk); #1;
    check("post_rst_rvalid", 64'(bus.rvalid_o), 64'h0);
    check("post_rst_init_done", 64'(bus.init_done_o), 64'h0);

    // Reset mid-fill at address 100; fill must restart from 0.
    @(negedge clk); bus.req_i = 2'b00; rst_n = 1'b1;
    fill_check(101);
    rst_n = 1'b0; #1;
    check("midfill_mem_req", 64'(bus.mem_req_o), 64'h0);
    @(negedge clk); #1;
    check("midfill_gnt", 64'(bus.gnt_o), 64'h0);
    check("midfill_rvalid", 64'(bus.rvalid_o), 64'h0);
    check("midfill_init_done", 64'(bus.init_done_o), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    fill_check(256);
    @(negedge clk); bus.req_i = 2'b01; bus.we_i = 2'b00; bus.addr_i[0] = 12'h010; #1;
    check("refill_init_done", 64'(bus.init_done_o), 64'h1);
    check("refill_gnt", 64'(bus.gnt_o), 64'h1);
    @(negedge clk); bus.req_i = 2'b00; #1;
    check("refill_rvalid", 64'(bus.rvalid_o), 64'h1);
    check("refill_rdata", bus.rdata_o, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Shares one single-port testbench SRAM (sram_wrapper-style: req/we/addr/wdata/be in, rdata one cycle later) between NumReq requesters with a mem_req/gnt/rvalid interface, e.g. the AXI-to-mem bridge plus a DPI preload/inspection port.
- After reset it zero-fills the whole SRAM, then arbitrates round-robin.
- Returns the read response to the granted requester exactly one cycle after grant.

Parameters:
- NumReq, 2, number of requesters (>=1).
- NumWords, 256, SRAM depth in words (power of two).
- DataWidth, 64, SRAM word width in bits (multiple of 8).
- AddrWidth, 12, requester byte-address width.
- InitZero, 1, 1 = zero-fill the SRAM after reset; 0 = skip the fill.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_i  in  NumReq  per-requester request.
- we_i  in  NumReq  per-requester write enable.
- addr_i  in  NumReq x AddrWidth  byte address.
- wdata_i  in  NumReq x DataWidth  write data.
- be_i  in  NumReq x DataWidth/8  byte enables.
- gnt_o  out  NumReq  one-hot grant.
- rvalid_o  out  NumReq  response valid, one-hot.
- rdata_o  out  DataWidth  read data, shared by all requesters.
- init_done_o  out  1  high once the zero-fill is complete.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  $clog2(NumWords)  SRAM word address.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_be_o  out  DataWidth/8  SRAM byte enables.
- mem_rdata_i  in  DataWidth  SRAM read data, valid one cycle after mem_req_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous, active-low, sampled on the clk_i rising edge.
- Reset values: gnt_o=0, rvalid_o=0, mem_req_o=0, mem_we_o=0, init_done_o=0, round-robin pointer=0, fill counter=0.
- Other outputs during reset: rdata_o follows mem_rdata_i. The mem_* data and address outputs are don't-care while mem_req_o=0.
- FSM states are INIT and RUN. After reset the FSM enters INIT if InitZero=1, else RUN.
- INIT state:
  - Every cycle: mem_req_o=1, mem_we_o=1, mem_be_o=all ones, mem_wdata_o=0, mem_addr_o=counter. The counter then increments.
  - After the write to address NumWords-1, the FSM goes to RUN the next cycle.
  - The fill takes NumWords cycles.
  - gnt_o=0 throughout, and requests stay pending.
  - init_done_o is set to 1 on entry to RUN and stays 1 until reset.
- RUN state, arbitration:
  - Combinational grant. Requester i wins if req_i[i]=1 and it is the first requester scanning from index ptr upward, wrapping modulo NumReq.
  - gnt_o is one-hot or zero. mem_req_o = |gnt_o.
  - The winner's we/wdata/be drive the mem_* outputs.
  - mem_addr_o = winner addr_i[log2(DataWidth/8) +: $clog2(NumWords)]. Upper address bits are ignored, so addresses alias.
  - On a grant, ptr <= (winner+1) mod NumReq. Without a grant, ptr holds.
  - A new grant is allowed every cycle. Back-to-back grants to different requesters are allowed.
- Response:
  - A registered one-hot copy of gnt_o drives rvalid_o one cycle after the grant. This happens for reads and writes alike.
  - rdata_o = mem_rdata_i and is meaningful only while rvalid_o is nonzero. For writes its value is undefined.
  - No response queueing: latency is always exactly 1 cycle.
- Requester protocol:
  - A requester holds req/addr/we/wdata/be stable until granted.
  - Dropping req before the grant is allowed. The request is simply not served and ptr is unaffected.
- Boundary cases:
  - All requesters asserting continuously: each is served once every NumReq cycles.
  - NumReq=1: the pointer stays 0 and the grant equals req_i[0] in RUN.
  - Reset asserted mid-fill or mid-transaction: the next cycle has all outputs at reset values, including a pending rvalid_o, which is dropped. The fill restarts from address 0.
  - A request asserted in the same cycle INIT ends is not granted until the first RUN cycle.

Test Plan:
- Reset, InitZero=1, NumWords=256: mem_req_o/mem_we_o high for exactly 256 cycles with addresses 0..255 and data 0. init_done_o rises on cycle 257. No gnt_o during the fill. A subsequent read of byte address 0x7F8 returns 0.
- RUN, requester 0 writes 0xDEADBEEF_CAFEF00D to byte address 0x10 (be=0xFF), then reads it back: gnt_o=01, rvalid_o=01 one cycle later each time. Read returns 0xDEADBEEF_CAFEF00D with mem_addr_o=2.
- Both requesters hold req for 6 cycles, ptr=0: grants alternate 01,10,01,10,01,10. rvalid_o repeats that pattern delayed by one cycle.
- Requester 1 alone is granted (ptr becomes 0). Next cycle both request: requester 0 is granted.
- Address aliasing: write 0x1 at byte address 0x008, then read byte address 0x808 (AddrWidth=12, NumWords=256): the read returns 0x1.
- Reset pulsed at fill address 100: after release, the fill restarts at 0 and takes a full 256 cycles. A read pending at reset produces no rvalid_o.
